// File: rtl/controlpath_pkg.sv
// Shared encodings, field positions and the decoded control bundle
// for the controlpath instruction sequencer.
package controlpath_pkg;

    localparam int INSTR_W = 33;

    typedef enum logic [1:0] {
        CLS_NOP  = 2'b00,
        CLS_ALU  = 2'b01,
        CLS_COPY = 2'b10,
        CLS_SETZ = 2'b11
    } cls_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int CLS_LO   = 31;
    localparam int OP_LO    = 28;
    localparam int FORM_B   = 27;
    localparam int PERCI_LO = 25;
    localparam int CONST_B  = 24;
    localparam int A_LO     = 20;
    localparam int B_LO     = 16;
    localparam int C_LO     = 12;
    localparam int D_LO     = 8;
    localparam int Y1_LO    = 4;
    localparam int Y2_LO    = 0;
    localparam int NEG_B    = 30;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_Y1   = 2'b01;
    localparam logic [1:0] WR_BOTH = 2'b11;

    typedef struct packed {
        logic       pc_inc;
        logic [2:0] alu_op;
        logic       alu_form;
        logic [1:0] vec_perci;
        logic       const_c;
        logic [3:0] zero_reg;
        logic [3:0] a_sel;
        logic [3:0] b_sel;
        logic [3:0] c_sel;
        logic [3:0] d_sel;
        logic [3:0] y1_sel;
        logic [3:0] y2_sel;
        logic [1:0] alu_write;
        logic       copy_neg;
        logic [3:0] copy_sel;
    } ctl_t;

endpackage

// File: rtl/controlpath_decode.sv
// Combinational instruction decode: the control bundle a RUN-state
// instruction produces, plus whether it starts a paired ALU op.
module controlpath_decode
    import controlpath_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instruction,
    input  logic [3:0]         i_zero_reg,
    output ctl_t               o_ctl,
    output logic               o_paired
);

    cls_e w_cls;
    logic w_form;

    assign w_cls  = cls_e'(i_instruction[CLS_LO +: 2]);
    assign w_form = i_instruction[FORM_B];

    always_comb begin
        o_ctl          = '0;
        o_ctl.zero_reg = i_zero_reg;
        o_ctl.pc_inc   = 1'b1;
        o_paired       = 1'b0;
        unique case (w_cls)
            CLS_ALU: begin
                o_ctl.alu_op    = i_instruction[OP_LO +: 3];
                o_ctl.alu_form  = w_form;
                o_ctl.vec_perci = i_instruction[PERCI_LO +: 2];
                o_ctl.const_c   = i_instruction[CONST_B];
                o_ctl.a_sel     = i_instruction[A_LO +: 4];
                o_ctl.b_sel     = i_instruction[B_LO +: 4];
                o_ctl.c_sel     = i_instruction[C_LO +: 4];
                o_ctl.d_sel     = i_instruction[D_LO +: 4];
                o_ctl.y1_sel    = i_instruction[Y1_LO +: 4];
                o_ctl.y2_sel    = i_instruction[Y2_LO +: 4];
                // Paired form writes both results on the follow-up cycle.
                o_ctl.alu_write = w_form ? WR_NONE : WR_Y1;
                o_ctl.pc_inc    = ~w_form;
                o_paired        = w_form;
            end
            CLS_COPY: begin
                o_ctl.copy_neg  = i_instruction[NEG_B];
                o_ctl.y1_sel    = i_instruction[Y1_LO +: 4];
                o_ctl.copy_sel  = i_instruction[Y2_LO +: 4];
                o_ctl.alu_write = WR_Y1;
            end
            CLS_SETZ: begin
                o_ctl.zero_reg = i_instruction[Y2_LO +: 4];
            end
            CLS_NOP: begin
            end
        endcase
    end

endmodule

// File: rtl/controlpath.sv
// Control path: RUN/HOLD sequencer with registered decode outputs.
// HOLD replays the paired ALU fields with both writes enabled.
module controlpath
    import controlpath_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  instruction,
    output logic                program_counter_inc,
    output logic [2:0]          alu_op,
    output logic                alu_form,
    output logic [1:0]          alu_vec_perci,
    output logic                const_c,
    output logic [3:0]          zero_reg,
    output logic [3:0]          alu_a_select,
    output logic [3:0]          alu_b_select,
    output logic [3:0]          alu_c_select,
    output logic [3:0]          alu_d_select,
    output logic [3:0]          alu_Y1_select,
    output logic [3:0]          alu_Y2_select,
    output logic [1:0]          alu_write,
    output logic                copy_neg,
    output logic [3:0]          copy_select
);

    state_e r_state;
    state_e w_state_nxt;
    ctl_t   r_ctl;
    ctl_t   w_dec;
    ctl_t   w_ctl_nxt;
    logic   w_paired;

    controlpath_decode u_decode (
        .i_instruction (instruction),
        .i_zero_reg    (r_ctl.zero_reg),
        .o_ctl         (w_dec),
        .o_paired      (w_paired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        w_ctl_nxt   = w_dec;
        unique case (r_state)
            ST_RUN: begin
                if (w_paired) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_ctl_nxt           = r_ctl;
                w_ctl_nxt.alu_write = WR_BOTH;
                w_ctl_nxt.pc_inc    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctl <= '0;
        end else begin
            r_ctl <= w_ctl_nxt;
        end
    end

    assign program_counter_inc = r_ctl.pc_inc;
    assign alu_op              = r_ctl.alu_op;
    assign alu_form            = r_ctl.alu_form;
    assign alu_vec_perci       = r_ctl.vec_perci;
    assign const_c             = r_ctl.const_c;
    assign zero_reg            = r_ctl.zero_reg;
    assign alu_a_select        = r_ctl.a_sel;
    assign alu_b_select        = r_ctl.b_sel;
    assign alu_c_select        = r_ctl.c_sel;
    assign alu_d_select        = r_ctl.d_sel;
    assign alu_Y1_select       = r_ctl.y1_sel;
    assign alu_Y2_select       = r_ctl.y2_sel;
    assign alu_write           = r_ctl.alu_write;
    assign copy_neg            = r_ctl.copy_neg;
    assign copy_select         = r_ctl.copy_sel;

endmodule

// File: tb/tb_controlpath.sv
// Scoreboard bench for controlpath: directed cases then random
// instructions, checked against a behavioural model.
module tb_controlpath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [32:0] instruction = '0;

    logic        program_counter_inc;
    logic [2:0]  alu_op;
    logic        alu_form;
    logic [1:0]  alu_vec_perci;
    logic        const_c;
    logic [3:0]  zero_reg;
    logic [3:0]  alu_a_select, alu_b_select, alu_c_select, alu_d_select;
    logic [3:0]  alu_Y1_select, alu_Y2_select;
    logic [1:0]  alu_write;
    logic        copy_neg;
    logic [3:0]  copy_select;

    controlpath dut (
        .clk                 (clk),
        .rst                 (rst),
        .instruction         (instruction),
        .program_counter_inc (program_counter_inc),
        .alu_op              (alu_op),
        .alu_form            (alu_form),
        .alu_vec_perci       (alu_vec_perci),
        .const_c             (const_c),
        .zero_reg            (zero_reg),
        .alu_a_select        (alu_a_select),
        .alu_b_select        (alu_b_select),
        .alu_c_select        (alu_c_select),
        .alu_d_select        (alu_d_select),
        .alu_Y1_select       (alu_Y1_select),
        .alu_Y2_select       (alu_Y2_select),
        .alu_write           (alu_write),
        .copy_neg            (copy_neg),
        .copy_select         (copy_select)
    );

    always #5 clk = ~clk;

    // Output image in a fixed order: pc,op,form,perci,const,zr,A,B,C,D,Y1,Y2,wr,neg,csel
    typedef struct {
        logic [42:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model state: pending second half of a paired op and the zero register.
    bit          m_hold = 0;
    logic [3:0]  m_z = '0;
    logic [42:0] m_last = '0;

    function automatic logic [42:0] pack(
        input logic pc, input logic [2:0] op, input logic form,
        input logic [1:0] perci, input logic cc, input logic [3:0] zr,
        input logic [23:0] sels, input logic [1:0] wr,
        input logic neg, input logic [3:0] cs);
        return {pc, op, form, perci, cc, zr, sels, wr, neg, cs};
    endfunction

    task automatic step(input logic r, input logic [32:0] ins, input string tag);
        exp_t e;
        logic [42:0] v;
        @(negedge clk);
        rst = r;
        instruction = ins;
        if (r) begin
            m_hold = 0;
            m_z = '0;
            v = '0;
        end else if (m_hold) begin
            m_hold = 0;
            v = m_last;
            v[42] = 1'b1;
            v[6:5] = 2'b11;
        end else begin
            case (ins[32:31])
                2'b01: begin
                    m_hold = ins[27];
                    v = pack(!ins[27], ins[30:28], ins[27], ins[26:25], ins[24],
                             m_z, ins[23:0], ins[27] ? 2'b00 : 2'b01, 1'b0, 4'h0);
                end
                2'b10: v = pack(1'b1, 3'd0, 1'b0, 2'd0, 1'b0, m_z,
                                {16'h0, ins[7:4], 4'h0}, 2'b01, ins[30], ins[3:0]);
                2'b11: begin
                    m_z = ins[3:0];
                    v = pack(1'b1, 3'd0, 1'b0, 2'd0, 1'b0, m_z,
                             24'h0, 2'b00, 1'b0, 4'h0);
                end
                default: v = pack(1'b1, 3'd0, 1'b0, 2'd0, 1'b0, m_z,
                                  24'h0, 2'b00, 1'b0, 4'h0);
            endcase
        end
        m_last = v;
        e.v = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [42:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {program_counter_inc, alu_op, alu_form, alu_vec_perci,
                       const_c, zero_reg, alu_a_select, alu_b_select,
                       alu_c_select, alu_d_select, alu_Y1_select,
                       alu_Y2_select, alu_write, copy_neg, copy_select};
                n_vec++;
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.tag, act, e.v);
                end
            end
        end
    end

    initial begin : driver
        logic [32:0] alu_s, alu_p, r;
        int guard;
        alu_s = {2'b01, 3'b101, 1'b0, 2'b10, 1'b1,
                 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        alu_p = alu_s;
        alu_p[27] = 1'b1;

        step(1'b1, 33'h0, "reset0");
        step(1'b1, 33'h0, "reset1");
        step(1'b0, alu_s, "alu_scalar");
        step(1'b0, alu_p, "alu_pair_c1");
        r = {$urandom, $urandom};
        step(1'b0, r, "alu_pair_c2");
        r = {2'b10, 1'b1, 22'h0, 4'd9, 4'd3};
        step(1'b0, r, "copy");
        r = {2'b11, 27'h5a5a5a, 4'hF};
        step(1'b0, r, "setz");
        step(1'b0, 33'h0_1234_5678, "nop_keep_z");
        r = {2'b10, 1'b0, 22'h3fffff, 4'd2, 4'd7};
        step(1'b0, r, "copy_keep_z");
        step(1'b0, alu_p, "alu_pair_keep_z");
        step(1'b0, alu_s, "hold_keep_z");
        step(1'b1, 33'h0, "reset_z");
        step(1'b0, alu_p, "pair_before_rst");
        step(1'b1, alu_s, "rst_in_hold");
        step(1'b0, 33'h0, "after_abort");

        for (int i = 0; i < 400; i++) begin
            r = {$urandom, $urandom};
            step(($urandom_range(0, 24) == 0), r, "random");
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
